// File: rtl/i_mem_pkg.sv
// Shared definitions for the instruction line-fill engine: line geometry
// and the fill FSM state encoding.
package i_mem_pkg;

  localparam int LINE_W        = 128;
  localparam int WORD_W        = 32;
  localparam int BEATS         = 4;
  localparam int LINE_OFF_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/i_line_fill_ctrl_if.sv
// Cache-side line request and memory-side word read port of the fill engine.
interface i_line_fill_ctrl_if #(
  parameter int ADDR_W = 32
);
  import i_mem_pkg::*;

  // Handshake: mem_read_start is a level request that the cache holds until
  // it sees the single-cycle mem_read_rdy pulse; mem_bus_data is valid in
  // that pulse cycle. The RAM side has no backpressure: each ram_rd cycle
  // returns ram_rdata exactly RD_LATENCY cycles later.
  logic              mem_read_start;
  logic [ADDR_W-1:0] mem_bus_address;
  logic [LINE_W-1:0] mem_bus_data;
  logic              mem_read_rdy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [WORD_W-1:0] ram_rdata;

  modport slave (
    input  mem_read_start, mem_bus_address, ram_rdata,
    output mem_bus_data, mem_read_rdy, ram_addr, ram_rd
  );

  modport master (
    output mem_read_start, mem_bus_address, ram_rdata,
    input  mem_bus_data, mem_read_rdy, ram_addr, ram_rd
  );

endinterface

// File: rtl/ram_resp_tracker.sv
// Fixed-latency shift register that tags each issued read with its beat
// index so the returning word lands in the right slot of the line.
module ram_resp_tracker #(
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [1:0] push_idx_i,
  output logic       cap_valid_o,
  output logic [1:0] cap_idx_o
);

  logic [RD_LATENCY-1:0] vld_q;
  logic [1:0]            idx_q [RD_LATENCY];

  // Stage k holds the beat whose ram_rd cycle ended k+1 edges ago, so the
  // last stage lines up with the cycle its data is on ram_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        idx_q[i] <= 2'd0;
      end
    end else begin
      vld_q[0] <= push_i;
      idx_q[0] <= push_idx_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign cap_valid_o = vld_q[RD_LATENCY-1];
  assign cap_idx_o   = idx_q[RD_LATENCY-1];

endmodule

// File: rtl/i_line_fill_ctrl.sv
// Instruction line-fill engine: reads a 16-byte line as four word reads
// from fixed-latency memory and returns it with a one-cycle ready pulse.
module i_line_fill_ctrl
  import i_mem_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  i_line_fill_ctrl_if.slave bus,
  output logic              busy,
  output fill_state_t       dbg_state_o
);

  localparam int BASE_W = ADDR_W - LINE_OFF_BITS;

  fill_state_t       state_q;
  logic [BASE_W-1:0] base_q;
  logic [1:0]        issue_cnt_q;
  logic [2:0]        cap_cnt_q;
  logic [LINE_W-1:0] line_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              rdy_q;
  logic              busy_q;

  logic              cap_valid;
  logic [1:0]        cap_idx;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.mem_bus_address[LINE_OFF_BITS-1:0];

  ram_resp_tracker #(
    .RD_LATENCY (RD_LATENCY)
  ) u_trk (
    .clk        (clk),
    .reset      (reset),
    .push_i     (rd_q),
    .push_idx_i (issue_cnt_q),
    .cap_valid_o(cap_valid),
    .cap_idx_o  (cap_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= 2'd0;
      cap_cnt_q   <= 3'd0;
      line_q      <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Captures run independently of state; with short latency they
      // overlap the tail of ISSUE.
      if (cap_valid) begin
        line_q[{cap_idx, 5'd0} +: WORD_W] <= bus.ram_rdata;
        cap_cnt_q <= cap_cnt_q + 3'd1;
      end
      case (state_q)
        IDLE: begin
          if (bus.mem_read_start) begin
            base_q      <= bus.mem_bus_address[ADDR_W-1:LINE_OFF_BITS];
            addr_q      <= {bus.mem_bus_address[ADDR_W-1:LINE_OFF_BITS], 4'h0};
            issue_cnt_q <= 2'd0;
            cap_cnt_q   <= 3'd0;
            rd_q        <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Only the word-select bits advance, so the line base never carries.
          if (issue_cnt_q == 2'(BEATS - 1)) begin
            rd_q    <= 1'b0;
            state_q <= DRAIN;
          end else begin
            issue_cnt_q <= issue_cnt_q + 2'd1;
            addr_q      <= {base_q, issue_cnt_q + 2'd1, 2'b00};
          end
        end
        DRAIN: begin
          if (cap_valid && (cap_cnt_q == 3'(BEATS - 1))) begin
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_bus_data = line_q;
  assign bus.mem_read_rdy = rdy_q;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_rd       = rd_q;
  assign busy             = busy_q;
  assign dbg_state_o      = state_q;

endmodule
